// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encodings, defaults, baud math.
// Kept identical on the TX and RX side so paired instances interoperate.
package uart_pkg;

   localparam logic [2:0] S_IDLE   = 3'b000;
   localparam logic [2:0] S_START  = 3'b001;
   localparam logic [2:0] S_DATA   = 3'b011;
   localparam logic [2:0] S_PARITY = 3'b100;
   localparam logic [2:0] S_STOP   = 3'b101;

   localparam int unsigned DEF_CLK_FRE     = 500;
   localparam int unsigned DEF_DATA_WIDTH  = 8;
   localparam int unsigned DEF_PARITY_ON   = 0;
   localparam int unsigned DEF_PARITY_TYPE = 0;
   localparam int unsigned DEF_BAUD_RATE   = 9600;
   localparam int unsigned DEF_STOP_BITS   = 1;

   // Clocks per bit; 64-bit intermediate avoids overflow of MHz*1e6.
   function automatic int unsigned calc_cycle(
      input int unsigned clk_fre,
      input int unsigned baud
   );
      logic [63:0] w_num;
      w_num = 64'(clk_fre) * 64'd1000000;
      return 32'(w_num / 64'(baud));
   endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: free-running 0..CYCLE-1 while enabled.
// Tick is high for the single clock where the count is CYCLE-1.
module uart_baud_gen #(
   parameter int unsigned CYCLE = 10
) (
   input  logic i_clk_sys,
   input  logic i_rst,
   input  logic i_en,
   input  logic i_clr,
   output logic o_tick
);

   localparam logic [31:0] LAST = 32'(CYCLE - 1);

   logic [31:0] r_cnt;

   assign o_tick = i_en && (r_cnt == LAST);

   // Count while enabled, wrap at CYCLE-1, hold at zero otherwise.
   always_ff @(posedge i_clk_sys or posedge i_rst) begin
      if (i_rst) begin
         r_cnt <= '0;
      end else if (i_clr || !i_en) begin
         r_cnt <= '0;
      end else if (r_cnt == LAST) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 32'd1;
      end
   end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, LSB-first data, optional parity, stop bits.
// Line output is registered; one word accepted per valid/ready handshake.
module uart_tx
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FRE     = DEF_CLK_FRE,
   parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int unsigned PARITY_ON   = DEF_PARITY_ON,
   parameter int unsigned PARITY_TYPE = DEF_PARITY_TYPE,
   parameter int unsigned BAUD_RATE   = DEF_BAUD_RATE,
   parameter int unsigned STOP_BITS   = DEF_STOP_BITS
) (
   input  logic                  i_clk_sys,
   input  logic                  i_rst,
   input  logic                  i_tx_valid,
   input  logic [DATA_WIDTH-1:0] i_tx_data,
   output logic                  o_tx_ready,
   output logic                  o_uart_tx,
   output logic                  o_tx_busy,
   output logic                  o_tx_done
);

   localparam int unsigned CYCLE     = calc_cycle(CLK_FRE, BAUD_RATE);
   localparam logic [3:0]  LAST_BIT  = 4'(DATA_WIDTH - 1);
   localparam logic [3:0]  LAST_STOP = 4'(STOP_BITS - 1);
   localparam logic        PAR_ODD   = 1'(PARITY_TYPE);

   logic [2:0]            r_state;
   logic [DATA_WIDTH-1:0] r_shift;
   logic [3:0]            r_cnt;
   logic                  r_parity;
   logic                  r_tx;
   logic                  r_ready;
   logic                  r_busy;
   logic                  r_done;

   logic w_accept;
   logic w_baud_en;
   logic w_tick;

   assign w_accept  = i_tx_valid && r_ready;
   assign w_baud_en = (r_state != S_IDLE);

   assign o_tx_ready = r_ready;
   assign o_uart_tx  = r_tx;
   assign o_tx_busy  = r_busy;
   assign o_tx_done  = r_done;

   uart_baud_gen #(
      .CYCLE(CYCLE)
   ) u_baud (
      .i_clk_sys(i_clk_sys),
      .i_rst    (i_rst),
      .i_en     (w_baud_en),
      .i_clr    (w_accept),
      .o_tick   (w_tick)
   );

   // Frame sequencer: every transition lands on a bit-period tick.
   always_ff @(posedge i_clk_sys or posedge i_rst) begin
      if (i_rst) begin
         r_state  <= S_IDLE;
         r_shift  <= '0;
         r_cnt    <= '0;
         r_parity <= 1'b0;
         r_tx     <= 1'b1;
         r_ready  <= 1'b1;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_state  <= S_START;
                  r_shift  <= i_tx_data;
                  r_parity <= (^i_tx_data) ^ PAR_ODD;
                  r_cnt    <= '0;
                  r_tx     <= 1'b0;
                  r_ready  <= 1'b0;
                  r_busy   <= 1'b1;
               end
            end
            S_START: begin
               if (w_tick) begin
                  r_state <= S_DATA;
                  r_tx    <= r_shift[0];
                  r_shift <= r_shift >> 1;
                  r_cnt   <= '0;
               end
            end
            S_DATA: begin
               if (w_tick) begin
                  if (r_cnt == LAST_BIT) begin
                     r_cnt <= '0;
                     if (PARITY_ON != 0) begin
                        r_state <= S_PARITY;
                        r_tx    <= r_parity;
                     end else begin
                        r_state <= S_STOP;
                        r_tx    <= 1'b1;
                     end
                  end else begin
                     r_cnt   <= r_cnt + 4'd1;
                     r_tx    <= r_shift[0];
                     r_shift <= r_shift >> 1;
                  end
               end
            end
            S_PARITY: begin
               if (w_tick) begin
                  r_state <= S_STOP;
                  r_tx    <= 1'b1;
               end
            end
            S_STOP: begin
               if (w_tick) begin
                  if (r_cnt == LAST_STOP) begin
                     r_state <= S_IDLE;
                     r_cnt   <= '0;
                     r_done  <= 1'b1;
                     r_ready <= 1'b1;
                     r_busy  <= 1'b0;
                  end else begin
                     r_cnt <= r_cnt + 4'd1;
                  end
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_tx    <= 1'b1;
               r_ready <= 1'b1;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Randomised self-checking bench for uart_tx.
// Three instances cover no-parity, even parity and odd parity with 2 stops.
module tb_uart_tx;

   localparam int CYC = 10;
   localparam int NU  = 3;
   localparam int PON [NU] = '{0, 1, 1};
   localparam int PTY [NU] = '{0, 0, 1};
   localparam int STP [NU] = '{1, 1, 2};

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       vld [NU];
   logic [7:0] dat [NU];
   wire        tx  [NU];
   wire        rdy [NU];
   wire        bsy [NU];
   wire        dn  [NU];

   int   n_chk = 0;
   int   n_err = 0;
   logic q [$];

   always #5 clk = ~clk;

   uart_tx #(
      .CLK_FRE(1), .DATA_WIDTH(8), .PARITY_ON(0),
      .PARITY_TYPE(0), .BAUD_RATE(100000), .STOP_BITS(1)
   ) u0 (
      .i_clk_sys(clk), .i_rst(rst),
      .i_tx_valid(vld[0]), .i_tx_data(dat[0]),
      .o_tx_ready(rdy[0]), .o_uart_tx(tx[0]),
      .o_tx_busy(bsy[0]), .o_tx_done(dn[0])
   );

   uart_tx #(
      .CLK_FRE(1), .DATA_WIDTH(8), .PARITY_ON(1),
      .PARITY_TYPE(0), .BAUD_RATE(100000), .STOP_BITS(1)
   ) u1 (
      .i_clk_sys(clk), .i_rst(rst),
      .i_tx_valid(vld[1]), .i_tx_data(dat[1]),
      .o_tx_ready(rdy[1]), .o_uart_tx(tx[1]),
      .o_tx_busy(bsy[1]), .o_tx_done(dn[1])
   );

   uart_tx #(
      .CLK_FRE(1), .DATA_WIDTH(8), .PARITY_ON(1),
      .PARITY_TYPE(1), .BAUD_RATE(100000), .STOP_BITS(2)
   ) u2 (
      .i_clk_sys(clk), .i_rst(rst),
      .i_tx_valid(vld[2]), .i_tx_data(dat[2]),
      .o_tx_ready(rdy[2]), .o_uart_tx(tx[2]),
      .o_tx_busy(bsy[2]), .o_tx_done(dn[2])
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Expected line bits of one frame, one entry per bit period.
   task automatic build(input int u, input logic [7:0] d);
      q.delete();
      q.push_back(1'b0);
      for (int i = 0; i < 8; i++) q.push_back(d[i]);
      if (PON[u] != 0) q.push_back(1'(($countones(d) + PTY[u]) % 2));
      for (int i = 0; i < STP[u]; i++) q.push_back(1'b1);
   endtask

   // Called at a negedge with the unit idle; ends at the done cycle
   // (hold=1) or after a short idle check (hold=0).
   task automatic run_frame(input int u, input logic [7:0] d,
                            input bit hold, input bit inject);
      int nb, m, nrl, nbh, ndl;
      build(u, d);
      nb = q.size();
      check($sformatf("u%0d ready_pre", u), 32'(rdy[u]), 1);
      vld[u] = 1'b1;
      dat[u] = d;
      @(posedge clk);
      nrl = 0; nbh = 0; ndl = 0;
      for (int b = 0; b < nb; b++) begin
         m = 0;
         for (int c = 0; c < CYC; c++) begin
            @(negedge clk);
            if (!hold && b == 0 && c == 0) begin
               vld[u] = 1'b0;
               dat[u] = 8'($urandom);
            end
            if (inject && b == 3 && c == 5) begin
               vld[u] = 1'b1;
               dat[u] = 8'hFF;
            end
            if (inject && b == 6 && c == 0) vld[u] = 1'b0;
            if (tx[u] === q[b]) m++;
            if (rdy[u] === 1'b0) nrl++;
            if (bsy[u] === 1'b1) nbh++;
            if (dn[u] === 1'b0) ndl++;
         end
         check($sformatf("u%0d d%02h bit%0d", u, d, b), m, CYC);
      end
      check($sformatf("u%0d ready_low", u), nrl, nb * CYC);
      check($sformatf("u%0d busy_high", u), nbh, nb * CYC);
      check($sformatf("u%0d done_low", u), ndl, nb * CYC);
      @(negedge clk);
      check($sformatf("u%0d done_pulse", u), 32'(dn[u]), 1);
      check($sformatf("u%0d ready_done", u), 32'(rdy[u]), 1);
      check($sformatf("u%0d busy_done", u), 32'(bsy[u]), 0);
      check($sformatf("u%0d line_done", u), 32'(tx[u]), 1);
      if (!hold) begin
         vld[u] = 1'b0;
         m = 0;
         for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (dn[u] === 1'b0 && tx[u] === 1'b1 && rdy[u] === 1'b1) m++;
         end
         check($sformatf("u%0d idle_after", u), m, 3);
      end
   endtask

   task automatic reset_mid();
      int m;
      vld[0] = 1'b1;
      dat[0] = 8'h96;
      @(posedge clk);
      for (int k = 0; k < 35; k++) begin
         @(negedge clk);
         if (k == 0) vld[0] = 1'b0;
      end
      check("rst pre_line", 32'(tx[0]), 1);
      check("rst pre_busy", 32'(bsy[0]), 1);
      #1 rst = 1'b1;
      #1;
      check("rst line", 32'(tx[0]), 1);
      check("rst ready", 32'(rdy[0]), 1);
      check("rst busy", 32'(bsy[0]), 0);
      m = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (dn[0] === 1'b0 && tx[0] === 1'b1) m++;
      end
      rst = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (dn[0] === 1'b0 && tx[0] === 1'b1 && rdy[0] === 1'b1) m++;
      end
      check("rst no_done", m, 24);
      run_frame(0, 8'h3C, 1'b0, 1'b0);
   endtask

   initial begin
      int m [NU];
      int u, pu;
      bit h, ph;
      logic [7:0] d;
      for (int i = 0; i < NU; i++) begin
         vld[i] = 1'b0;
         dat[i] = 8'h00;
      end
      rst = 1'b1;
      repeat (3) @(negedge clk);
      for (int i = 0; i < NU; i++) begin
         check($sformatf("u%0d reset_line", i), 32'(tx[i]), 1);
         check($sformatf("u%0d reset_ready", i), 32'(rdy[i]), 1);
         check($sformatf("u%0d reset_busy", i), 32'(bsy[i]), 0);
         check($sformatf("u%0d reset_done", i), 32'(dn[i]), 0);
      end
      rst = 1'b0;
      for (int i = 0; i < NU; i++) m[i] = 0;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         for (int i = 0; i < NU; i++)
            if (tx[i] === 1'b1 && rdy[i] === 1'b1 && dn[i] === 1'b0)
               m[i]++;
      end
      for (int i = 0; i < NU; i++)
         check($sformatf("u%0d idle50", i), m[i], 50);

      run_frame(0, 8'hA5, 1'b0, 1'b0);
      run_frame(1, 8'h07, 1'b0, 1'b0);
      run_frame(2, 8'h07, 1'b0, 1'b0);
      run_frame(0, 8'h55, 1'b1, 1'b0);
      run_frame(0, 8'hAA, 1'b0, 1'b0);
      run_frame(0, 8'h5A, 1'b0, 1'b1);
      reset_mid();

      ph = 1'b0;
      pu = 0;
      for (int n = 0; n < 12; n++) begin
         u = ph ? pu : int'($urandom_range(0, NU - 1));
         d = 8'($urandom);
         h = (n == 11) ? 1'b0 : 1'($urandom_range(0, 1));
         run_frame(u, d, h, 1'b0);
         pu = u;
         ph = h;
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART transmitter; the counterpart of the team's UART receiver. Use the same parameter set so that paired instances interoperate.
- Accepts one DATA_WIDTH word per valid/ready handshake from the system side.
- Serialises each word as: start bit (0), data LSB-first, optional parity, stop bit(s) (1).
- Sits between the CPU/peripheral bus side and the board TX pin, on the system clock.

Parameters:
- CLK_FRE, 500: system clock frequency in MHz.
- DATA_WIDTH, 8: data bits per frame; legal range 5..9.
- PARITY_ON, 0: 1 inserts a parity bit; 0 means no parity bit.
- PARITY_TYPE, 0: 1 selects odd parity, 0 selects even parity.
- BAUD_RATE, 9600: line bit rate in bit/s.
- STOP_BITS, 1: number of stop bits; legal values 1 or 2.

Ports:
- i_clk_sys  input  1  system clock; all logic on its rising edge.
- i_rst  input  1  reset; asynchronous, active-high.
- i_tx_valid  input  1  i_tx_data is valid and requests transmission.
- i_tx_data  input  DATA_WIDTH  word to transmit.
- o_tx_ready  output  1  block can accept a word this cycle.
- o_uart_tx  output  1  serial line; idles high.
- o_tx_busy  output  1  frame in progress.
- o_tx_done  output  1  one-cycle pulse when a frame completes.

Behaviour:
- CYCLE = CLK_FRE*1000000/BAUD_RATE, integer division. Every bit lasts exactly CYCLE clocks.
- Reset values (async on i_rst high): o_uart_tx=1, o_tx_ready=1, o_tx_busy=0, o_tx_done=0, state=IDLE, counters=0, shift register=0.
- Handshake:
  - Accept happens when i_tx_valid && o_tx_ready at a rising edge.
  - On accept, latch i_tx_data; compute parity = (^i_tx_data) ^ PARITY_TYPE.
  - o_tx_ready=0 and o_tx_busy=1 from the next cycle.
  - i_tx_valid while o_tx_ready=0 is ignored; the word is not queued and i_tx_data need not be held after accept.
- Latency: o_uart_tx drops to 0 in the clock after accept.
- Frame length: (1 + DATA_WIDTH + PARITY_ON + STOP_BITS)*CYCLE clocks.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START on accept.
  - START -> DATA after CYCLE clocks.
  - DATA: emits shift[0], shifts right every CYCLE clocks, counts bits. After DATA_WIDTH bits, goes to PARITY if PARITY_ON, else STOP.
  - PARITY -> STOP after CYCLE clocks.
  - STOP: line=1 for STOP_BITS*CYCLE clocks, then -> IDLE.
- Completion:
  - On STOP -> IDLE: o_tx_done=1 for exactly one cycle; o_tx_ready=1 and o_tx_busy=0 in that same cycle.
  - Back-to-back: an accept in the o_tx_done cycle is legal. The next start bit follows one clock later, so the gap between the last stop bit and the next start bit is exactly 1 clock of idle-high.
- Baud counter:
  - 32-bit, cleared on accept.
  - Counts 0..CYCLE-1 and wraps; a tick fires at count CYCLE-1.
  - Held at 0 in IDLE.
- o_uart_tx is registered, so no glitches on state change.
- Reset mid-frame: line returns to 1 immediately, the frame is abandoned with no o_tx_done, and o_tx_ready=1 after reset deasserts.
- Parity check: receiver sum of data bits + parity bit (mod 2) must equal PARITY_TYPE.

Decomposition:
- Shared package uart_pkg holds:
  - state encodings (IDLE=3'b000, START=3'b001, DATA=3'b011, PARITY=3'b100, STOP=3'b101), matching the receiver;
  - a CYCLE computation function;
  - default parameter constants.
- One natural sub-module, uart_baud_gen: parameter CYCLE; input enable/clear; output 1-clock tick at CYCLE-1. Reusable by the receiver.

Test Plan:
All scenarios use CLK_FRE=1, BAUD_RATE=100000 (CYCLE=10) unless stated.
- After reset, hold idle 50 clks -> o_uart_tx=1, o_tx_ready=1, o_tx_done=0 throughout.
- Send 8'hA5, no parity -> line 0 (10 clks), then 1,0,1,0,0,1,0,1 (10 clks each), then 1 (10 clks). o_tx_done pulses at clk 100 after accept.
- PARITY_ON=1, PARITY_TYPE=0, send 8'h07 -> parity bit=1, frame 110 clks. With PARITY_TYPE=1 -> parity bit=0.
- Send 8'h55 and 8'hAA back-to-back with i_tx_valid held -> second start bit exactly 1 clk after first stop ends; both decode correctly by loopback into the team's receiver.
- Assert i_tx_valid during a frame with 8'hFF -> ignored; o_tx_ready stays 0 and the line shows only the original frame.
- Assert i_rst at clk 35 of a frame -> o_uart_tx=1 the same cycle, no o_tx_done; a new send of 8'h3C afterwards completes correctly.
